// File: rtl/isqrt_core.sv
// Iterative unsigned integer square root, restoring digit-by-digit method.
// Produces one root bit per clock; results are held until the next accepted start.
module isqrt_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic [WIDTH-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   remainder
);

    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 2;
    localparam int CW = $clog2(HW) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [RW-1:0]    r_r;
    logic [HW-1:0]    r_q;
    logic [CW-1:0]    r_cnt;
    logic [HW-1:0]    r_root;
    logic [HW:0]      r_rem;

    logic [RW-1:0]    w_t;
    logic [RW-1:0]    w_d;
    logic             w_ge;
    logic [RW-1:0]    w_r_nxt;
    logic [HW-1:0]    w_q_nxt;
    logic             w_last;
    logic             w_accept;

    // One restoring iteration: bring down the next radicand digit pair and trial-subtract 4q+1.
    always_comb begin
        w_t     = (r_r << 2) | RW'(r_x[WIDTH-1 -: 2]);
        w_d     = ({2'b00, r_q} << 2) | RW'(1);
        w_ge    = (w_t >= w_d);
        w_r_nxt = w_ge ? (w_t - w_d) : w_t;
        w_q_nxt = (r_q << 1) | HW'(w_ge);
    end

    assign w_last   = (r_cnt == CW'(HW - 1));
    assign w_accept = start && !clear && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_CALC;
            S_CALC: begin
                if (clear)       w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = w_accept ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers only change on the final iteration, so an abort leaves the last result intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_r    <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_root <= '0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_x   <= radicand;
            r_r   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if ((r_state == S_CALC) && !clear) begin
            r_x   <= r_x << 2;
            r_r   <= w_r_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_root <= w_q_nxt;
                r_rem  <= w_r_nxt[HW:0];
            end
        end
    end

    assign busy      = (r_state == S_CALC);
    assign done      = (r_state == S_DONE);
    assign root      = r_root;
    assign remainder = r_rem;

endmodule

// File: doc/isqrt_core.md
# isqrt_core

Iterative unsigned integer square-root engine. It sits directly downstream of the memory-mapped SQRT accelerator wrapper at 0x600–0x6FF: the wrapper converts processor stores into a `start` pulse plus a radicand, and reads back `busy`, `done`, `root` and `remainder`. The engine produces one root bit per clock using the restoring digit-by-digit method. Results stay held until the next accepted start.

## Interface
- `WIDTH`, default 32: radicand width. Must be even and ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request a computation. Sampled only when `state` is IDLE or DONE.
- `clear`  in  1  synchronous abort. Returns the engine to IDLE; output registers are kept.
- `radicand`  in  WIDTH  operand. Captured on the edge that accepts `start`.
- `busy`  out  1  high while `state` is CALC.
- `done`  out  1  high for exactly one cycle while `state` is DONE.
- `root`  out  WIDTH/2  floor(sqrt(radicand)).
- `remainder`  out  WIDTH/2+1  radicand − root².

## Operation
- States: IDLE, CALC, DONE. Encoding is free.
- Working registers:
  - `x`: WIDTH bits, radicand shift register.
  - `r`: WIDTH/2+2 bits, partial remainder, unsigned.
  - `q`: WIDTH/2 bits, partial root.
  - `cnt`: clog2(WIDTH/2)+1 bits.
- Accept condition: `start` is high, `clear` is low, and `state` is IDLE or DONE.
- On accept, load:
  - `x` ← `radicand`
  - `r` ← 0
  - `q` ← 0
  - `cnt` ← 0
  - `state` ← CALC
- Each CALC cycle performs one iteration:
  - `t` = (`r` << 2) | `x`[WIDTH−1:WIDTH−2]
  - `d` = (`q` << 2) | 1, zero-extended to the width of `r`
  - If `t` ≥ `d`: `r` ← `t` − `d`, `q` ← (`q` << 1) | 1.
  - Otherwise: `r` ← `t`, `q` ← `q` << 1.
  - `x` ← `x` << 2
  - `cnt` ← `cnt` + 1
- On the iteration with `cnt` = WIDTH/2−1:
  - `state` ← DONE.
  - `root` ← the new `q` value; `remainder` ← the new `r` value (truncated to WIDTH/2+1 bits, never lossy).
  - The output registers are written only at this point.
- DONE always leaves after one cycle:
  - `start` accepted: go to CALC.
  - No `start`: go to IDLE.
- `start` in CALC is ignored. It is not queued and `radicand` is not sampled.
- `clear`:
  - In CALC: `state` ← IDLE and `busy` drops next cycle. No `done` is produced, and `root`/`remainder` keep their previous values.
  - Has priority over `start` in the same cycle.
  - In IDLE or DONE: `state` ← IDLE.
- `reset`, asserted at any time including mid-CALC:
  - Forces IDLE immediately, asynchronously.
  - Zeroes `x`, `r`, `q`, `cnt`, `root` and `remainder`.
  - `busy` = 0 and `done` = 0.
- Arithmetic is unsigned throughout. `r` never exceeds 2·`q`+1 and fits in WIDTH/2+2 bits without overflow.

## Timing
- Reset values: `busy`=0, `done`=0, `root`=0, `remainder`=0, `state`=IDLE.
- `busy` and `done` are decoded directly from registered `state`, with no combinational path from `start`.
- With `start` accepted at edge k:
  - `busy` is high for the cycles after edges k … k+WIDTH/2−1. For WIDTH=32 that is 16 cycles.
  - `done` is high for the single cycle after edge k+WIDTH/2.
  - `root`/`remainder` change exactly at edge k+WIDTH/2 and are stable while `done`=1.
- Start-to-done latency is WIDTH/2 cycles.
- Back-to-back: `start` held during DONE is accepted and `busy` rises the next cycle. Sustained throughput is one result per WIDTH/2+1 cycles.
- No combinational path from any input to any output.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs read 0 before the next edge and stay 0 while `reset` is held.
- **Basic values (WIDTH=32):**
  - 0 → `root`=0, `remainder`=0.
  - 1 → 1, 0.
  - 17 → 4, 1.
  - 1000000 → 1000, 0.
  - 0xFFFFFFFF → 0xFFFF, 0x1FFFE.
  - Each with `done` exactly 16 cycles after the start edge and lasting 1 cycle.
- **Ignored start:** compute 17, then pulse `start` with `radicand`=100 during CALC cycle 5 → result is still 4/1, only one `done` pulse, `busy` is high for exactly 16 cycles.
- **Clear:**
  - Start 81, then assert `clear` at CALC cycle 8 → `busy` falls next cycle, no `done`, outputs keep the prior result.
  - Follow with start 81 → 9, 0.
- **Reset mid-operation:** start 0xFFFFFFFF, assert `reset` at CALC cycle 10 → outputs 0. After release, start 144 → 12, 0 with correct latency.
- **Back-to-back and random:**
  - Hold `start` high with a new operand each DONE cycle → results every 17 cycles, all correct.
  - Run 10k random operands against a floor-sqrt reference model, including the boundaries 2^32−1, n², n²−1 and n²+2n.
